// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit (LSL, LSR, ASR, ROR) with saturating amounts and a START/BUSY/DONE handshake.
// Optional macro ITER_SHIFT_FAST_EN: move two bit positions per RUN cycle while at least two remain.
module iter_shift_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] IN,
   input  logic [7:0]       SHIFT,
   input  logic [1:0]       SHIFT_TYPE,
   output logic [WIDTH-1:0] OUT,
   output logic             BUSY,
   output logic             DONE
);

   localparam int LOG_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   logic [1:0]       state;
   logic [WIDTH-1:0] op;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       typ;
   logic [CNT_W-1:0] eff_cnt;

   // Shifts saturate at WIDTH positions; a rotate only needs the amount modulo WIDTH.
   always_comb begin
      eff_cnt = '0;
      if (SHIFT_TYPE == OP_ROR)
         eff_cnt = CNT_W'(SHIFT[LOG_W-1:0]);
      else if (32'(SHIFT) >= 32'(WIDTH))
         eff_cnt = CNT_W'(WIDTH);
      else
         eff_cnt = CNT_W'(SHIFT);
   end

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [1:0] t);
      logic [WIDTH-1:0] r;
      case (t)
         OP_LSL:  r = {v[WIDTH-2:0], 1'b0};
         OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
         OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = {v[0], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= ST_IDLE;
         op    <= '0;
         cnt   <= '0;
         typ   <= '0;
         OUT   <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE, ST_FIN: begin
               // FIN accepts a new request just like IDLE so operations can run back to back.
               if (START) begin
                  op    <= IN;
                  typ   <= SHIFT_TYPE;
                  cnt   <= eff_cnt;
                  BUSY  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cnt != '0) begin
`ifdef ITER_SHIFT_FAST_EN
                  if (cnt >= CNT_W'(2)) begin
                     op  <= step1(step1(op, typ), typ);
                     cnt <= cnt - CNT_W'(2);
                  end else begin
                     op  <= step1(op, typ);
                     cnt <= cnt - CNT_W'(1);
                  end
`else
                  op  <= step1(op, typ);
                  cnt <= cnt - CNT_W'(1);
`endif
               end else begin
                  OUT   <= op;
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= ST_FIN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed test-plan vectors plus random operations
// checked against an arithmetic reference model of results and latency.
module tb_iter_shift_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_v = '0;
   logic [7:0] shift_v = '0;
   logic [1:0] type_v = '0;
   logic [7:0] out_v;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   localparam int NDIR = 10;
   localparam logic [7:0] D_IN    [NDIR] = '{8'h15, 8'h80, 8'hFF, 8'hFF, 8'h81, 8'h81, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
   localparam logic [7:0] D_SH    [NDIR] = '{8'd3, 8'd3, 8'd200, 8'd200, 8'd9, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam logic [1:0] D_TY    [NDIR] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   localparam logic [7:0] D_EXP   [NDIR] = '{8'hA8, 8'hF0, 8'hFF, 8'h00, 8'hC0, 8'h81, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

   always #5 clk = ~clk;

   iter_shift_unit dut (
      .CLK        (clk),
      .RESET      (rst_n),
      .START      (start),
      .IN         (in_v),
      .SHIFT      (shift_v),
      .SHIFT_TYPE (type_v),
      .OUT        (out_v),
      .BUSY       (busy),
      .DONE       (done)
   );

   // Reference result straight from the operation definitions, using whole-word shifts.
   function automatic logic [7:0] model_result(input logic [7:0] a, input logic [7:0] sh, input logic [1:0] t);
      logic [7:0]        r;
      logic signed [7:0] sa;
      int                k;
      sa = a;
      k  = int'(sh);
      case (t)
         2'd0:    r = (k >= 8) ? 8'h00 : 8'(a << k);
         2'd1:    r = (k >= 8) ? 8'h00 : 8'(a >> k);
         2'd2:    r = 8'(sa >>> ((k >= 8) ? 7 : k));
         default: begin
            k = k % 8;
            r = 8'((a >> k) | (a << (8 - k)));
         end
      endcase
      return r;
   endfunction

   function automatic int model_latency(input logic [7:0] sh, input logic [1:0] t);
      int eff;
      eff = (t == 2'd3) ? (int'(sh) % 8) : ((int'(sh) > 8) ? 8 : int'(sh));
`ifdef ITER_SHIFT_FAST_EN
      return 1 + (eff + 1) / 2;
`else
      return 1 + eff;
`endif
   endfunction

   // Issues one request from mid-cycle, scrambles inputs after capture, and waits (bounded) for DONE.
   task automatic drive_op(input logic [7:0] a, input logic [7:0] sh, input logic [1:0] t,
                           output logic [7:0] res, output int lat, output bit hs_ok);
      logic [7:0] held;
      held  = out_v;
      hs_ok = 1'b1;
      lat   = -1;
      res   = 'x;
      start = 1'b1; in_v = a; shift_v = sh; type_v = t;
      @(posedge clk); #1;
      start = 1'b0; in_v = 8'($urandom); shift_v = 8'($urandom); type_v = 2'($urandom);
      if (busy !== 1'b1 || done !== 1'b0) hs_ok = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            res = out_v;
            lat = n;
            if (busy !== 1'b0) hs_ok = 1'b0;
            break;
         end
         if (busy !== 1'b1 || out_v !== held) hs_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (out_v !== 8'h00) begin errors++; $display("[TB] FAIL reset_out got=%h want=00", out_v); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [7:0] res;
      int         lat;
      bit         ok;
      for (int i = 0; i < NDIR; i++) begin
         drive_op(D_IN[i], D_SH[i], D_TY[i], res, lat, ok);
         checks++; if (res !== D_EXP[i]) begin errors++; $display("[TB] FAIL dir%0d_out got=%h want=%h", i, res, D_EXP[i]); end
         checks++; if (lat !== model_latency(D_SH[i], D_TY[i])) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d want=%0d", i, lat, model_latency(D_SH[i], D_TY[i])); end
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_handshake busy/done/out-hold violated", i); end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_random();
      logic [7:0] a, sh, res;
      logic [1:0] t;
      int         lat;
      bit         ok;
      for (int i = 0; i < 40; i++) begin
         a  = 8'($urandom);
         sh = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
         t  = 2'($urandom);
         drive_op(a, sh, t, res, lat, ok);
         checks++; if (res !== model_result(a, sh, t)) begin errors++; $display("[TB] FAIL rnd%0d_out in=%h sh=%0d ty=%0d got=%h want=%h", i, a, sh, t, res, model_result(a, sh, t)); end
         checks++; if (lat !== model_latency(sh, t)) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d want=%0d", i, lat, model_latency(sh, t)); end
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_handshake busy/done/out-hold violated", i); end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   // The second request is raised in the FIN cycle, right after the first DONE is seen.
   task automatic test_back_to_back();
      logic [7:0] res;
      int         lat;
      bit         ok;
      drive_op(8'h5A, 8'd0, 2'd0, res, lat, ok);
      checks++; if (res !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_first_out got=%h want=5a", res); end
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL b2b_first_latency got=%0d want=1", lat); end
      drive_op(8'h01, 8'd1, 2'd0, res, lat, ok);
      checks++; if (res !== 8'h02) begin errors++; $display("[TB] FAIL b2b_second_out got=%h want=02", res); end
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL b2b_second_latency got=%0d want=2", lat); end
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_handshake busy/done/out-hold violated"); end
      @(posedge clk); #1;
   endtask

   task automatic test_start_during_run();
      logic [7:0] res;
      int         lat;
      int         stray;
      lat = -1; res = 'x; stray = 0;
      start = 1'b1; in_v = 8'h15; shift_v = 8'd3; type_v = 2'd0;
      @(posedge clk); #1;
      for (int n = 1; n <= 20; n++) begin
         start = (n == 2);
         if (n == 2) begin in_v = 8'hFF; shift_v = 8'd1; type_v = 2'd1; end
         @(posedge clk); #1;
         if (done === 1'b1) begin res = out_v; lat = n; break; end
      end
      start = 1'b0;
      checks++; if (res !== 8'hA8) begin errors++; $display("[TB] FAIL run_restart_out got=%h want=a8", res); end
      checks++; if (lat !== model_latency(8'd3, 2'd0)) begin errors++; $display("[TB] FAIL run_restart_latency got=%0d want=%0d", lat, model_latency(8'd3, 2'd0)); end
      repeat (4) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL run_restart_idle got=%0d busy/done cycles want=0", stray); end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] res;
      int         lat;
      int         stray;
      bit         ok;
      stray = 0;
      start = 1'b1; in_v = 8'hFF; shift_v = 8'd8; type_v = 2'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (out_v !== 8'h00) begin errors++; $display("[TB] FAIL midrst_out got=%h want=00", out_v); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0 || out_v !== 8'h00) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midrst_no_done got=%0d bad cycles want=0", stray); end
      drive_op(8'h15, 8'd3, 2'd0, res, lat, ok);
      checks++; if (res !== 8'hA8) begin errors++; $display("[TB] FAIL midrst_after_out got=%h want=a8", res); end
      checks++; if (lat !== model_latency(8'd3, 2'd0)) begin errors++; $display("[TB] FAIL midrst_after_latency got=%0d want=%0d", lat, model_latency(8'd3, 2'd0)); end
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL midrst_after_handshake busy/done/out-hold violated"); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_during_run();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Multi-cycle 8-bit shift/rotate execution unit in the ALU datapath. It sits downstream of operand read and feeds the ALU result mux alongside the single-cycle SHIFTER. It covers what the combinational shifter does not:
- rotate right;
- shift amounts up to 8'd255, with saturation.

It applies one bit position per clock and uses a START/BUSY/DONE handshake to the control unit.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, minimum 4.
- CNT_W, $clog2(WIDTH)+1, remaining-step counter width; holds values 0..WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request pulse; sampled on the rising edge of CLK.
- IN  input  WIDTH  operand, signed for arithmetic right shift.
- SHIFT  input  8  shift amount, unsigned.
- SHIFT_TYPE  input  2  operation select:
  - 00 logical left (LSL)
  - 01 logical right (LSR)
  - 10 arithmetic right (ASR)
  - 11 rotate right (ROR)
- OUT  output  WIDTH  result register; holds its value until the next completion.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; OUT is valid in the same cycle.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, OUT=0, BUSY=0, DONE=0, internal operand/count/type registers cleared.
- Reset mid-operation aborts it immediately. No DONE is produced. OUT returns to 0.
- States: IDLE, RUN, FIN.
  - IDLE: START=1 latches IN, SHIFT_TYPE and the effective count. Next state RUN; BUSY=1.
  - RUN: if count>0, one step on the operand and count-1. If count==0, copy operand to OUT, DONE=1, BUSY=0, next state FIN.
  - FIN: DONE=0. START=1 here is accepted exactly as in IDLE (back-to-back operations). Otherwise go to IDLE.
- Effective count:
  - LSL, LSR, ASR: min(SHIFT, WIDTH).
  - ROR: SHIFT mod WIDTH, i.e. the low $clog2(WIDTH) bits.
- Step definitions:
  - LSL: {op[W-2:0],0}
  - LSR: {0,op[W-1:1]}
  - ASR: {op[W-1],op[W-1:1]}
  - ROR: {op[0],op[W-1:1]}
- Saturation results:
  - LSL/LSR with SHIFT>=WIDTH gives 0.
  - ASR with SHIFT>=WIDTH gives all copies of the sign bit.
- Latency: START sampled at edge k; DONE high after edge k+1+eff.
  - eff=0: DONE after edge k+1, OUT=IN.
  - Maximum latency is WIDTH+1 edges.
- START while in RUN is ignored. The in-flight operation is unaffected.
- Input changes after capture have no effect on the result.
- OUT changes only on the edge that raises DONE, or on reset.
- BUSY is exactly 1 from the capture edge up to, but not including, the DONE edge.
- BUSY and DONE are never both 1.

Optional Feature:
Macro ITER_SHIFT_FAST_EN.
- Defined: each RUN step moves 2 bit positions when count>=2, and 1 position when count==1. Count decrements by the same amount. Step count becomes ceil(eff/2), so DONE comes after edge k+1+ceil(eff/2). Results are bit-identical to the undefined build.
- Undefined: 1 position per cycle, as specified above.

Test Plan:
- IN=8'h15, SHIFT=3, LSL, START at edge k -> BUSY over edges k..k+3, DONE after edge k+4, OUT=8'hA8. FAST build: DONE after edge k+3.
- IN=8'h80, SHIFT=3, ASR -> OUT=8'hF0. Then IN=8'hFF, SHIFT=8'd200, ASR -> OUT=8'hFF with DONE after edge k+9 (saturated at 8). Then same operand, LSR, SHIFT=200 -> OUT=8'h00.
- IN=8'h81, SHIFT=9, ROR -> eff=1, OUT=8'hC0, DONE after edge k+2. With SHIFT=8 -> OUT=8'h81, DONE after edge k+1.
- SHIFT=0, IN=8'h5A, any type -> DONE after edge k+1, OUT=8'h5A. Then START held high in the FIN cycle with IN=8'h01, LSL, SHIFT=1 -> second DONE two edges later, OUT=8'h02.
- START re-pulsed during RUN with different IN and SHIFT -> ignored; first result unchanged (8'h15 LSL 3 = 8'hA8).
- RESET driven low mid-RUN between clock edges -> OUT=0, BUSY=0, DONE=0 immediately, no DONE pulse. After release, a new START operates normally.
